// File: rtl/sap2_control_sequencer.sv
// SAP-2 fetch/decode/operand/execute sequencer driving PC, MAR, memory and IR
// control strobes, with instruction-length decode and a retired-instruction counter.
module sap2_control_sequencer #(
  parameter logic [7:0]  HLT_OPCODE = 8'h76,
  parameter int unsigned RETIRE_W   = 16
) (
  input  logic                iClk,
  input  logic                iReset_n,
  input  logic [7:0]          iInstruction,
  input  logic                iMemReady,
  input  logic                iExecDone,
  output logic                oPcOut,
  output logic                oMarLoad,
  output logic                oMemRead,
  output logic                oPcInc,
  output logic                oIrLoad,
  output logic                oOpLoLoad,
  output logic                oOpHiLoad,
  output logic                oExecStart,
  output logic                oHalted,
  output logic [3:0]          oState,
  output logic [RETIRE_W-1:0] oRetired
);

  typedef enum logic [3:0] {
    F_ADDR = 4'd0,
    F_MEM  = 4'd1,
    DECODE = 4'd2,
    O_ADDR = 4'd3,
    O_MEM  = 4'd4,
    EXEC   = 4'd5,
    WAIT   = 4'd6,
    HALT   = 4'd7
  } state_t;

  state_t                r_state, w_next;
  logic [1:0]            r_bytes_left, w_bytes_left_nxt;
  logic                  r_op_idx, w_op_idx_nxt;
  logic [RETIRE_W-1:0]   r_retired;
  logic                  w_retire;
  logic [1:0]            w_len;
  logic                  w_pc_out, w_mar_load, w_mem_read, w_pc_inc;
  logic                  w_ir_load, w_op_lo, w_op_hi, w_exec_start;

  always_comb begin
    unique case (iInstruction)
      8'h3A, 8'h32, 8'hC3, 8'hCD, 8'hFA, 8'hC2, 8'hCA:         w_len = 2'd3;
      8'h3E, 8'h06, 8'h0E, 8'hE6, 8'hF6, 8'hEE, 8'hDB, 8'hD3: w_len = 2'd2;
      default:                                                w_len = 2'd1;
    endcase
  end

  always_comb begin
    w_next           = r_state;
    w_bytes_left_nxt = r_bytes_left;
    w_op_idx_nxt     = r_op_idx;
    w_retire         = 1'b0;
    w_pc_out         = 1'b0;
    w_mar_load       = 1'b0;
    w_mem_read       = 1'b0;
    w_pc_inc         = 1'b0;
    w_ir_load        = 1'b0;
    w_op_lo          = 1'b0;
    w_op_hi          = 1'b0;
    w_exec_start     = 1'b0;
    unique case (r_state)
      F_ADDR: begin
        w_pc_out   = 1'b1;
        w_mar_load = 1'b1;
        w_next     = F_MEM;
      end
      F_MEM: begin
        w_mem_read = 1'b1;
        if (iMemReady) begin
          w_ir_load = 1'b1;
          w_pc_inc  = 1'b1;
          w_next    = DECODE;
        end
      end
      DECODE: begin
        if (iInstruction == HLT_OPCODE) begin
          w_retire = 1'b1;
          w_next   = HALT;
        end else if (w_len != 2'd1) begin
          w_bytes_left_nxt = w_len - 2'd1;
          w_op_idx_nxt     = 1'b0;
          w_next           = O_ADDR;
        end else begin
          w_next = EXEC;
        end
      end
      O_ADDR: begin
        w_pc_out   = 1'b1;
        w_mar_load = 1'b1;
        w_next     = O_MEM;
      end
      O_MEM: begin
        w_mem_read = 1'b1;
        if (iMemReady) begin
          w_pc_inc         = 1'b1;
          w_op_lo          = ~r_op_idx;
          w_op_hi          = r_op_idx;
          w_bytes_left_nxt = r_bytes_left - 2'd1;
          w_op_idx_nxt     = 1'b1;
          w_next           = (r_bytes_left == 2'd1) ? EXEC : O_ADDR;
        end
      end
      EXEC: begin
        w_exec_start = 1'b1;
        w_next       = WAIT;
      end
      WAIT: begin
        if (iExecDone) begin
          w_retire = 1'b1;
          w_next   = F_ADDR;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = F_ADDR;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      r_state      <= F_ADDR;
      r_bytes_left <= '0;
      r_op_idx     <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state      <= w_next;
      r_bytes_left <= w_bytes_left_nxt;
      r_op_idx     <= w_op_idx_nxt;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  // Reset returns the state to F_ADDR, whose strobes are active; gating with
  // iReset_n keeps every strobe low for as long as reset is held.
  assign oPcOut     = iReset_n & w_pc_out;
  assign oMarLoad   = iReset_n & w_mar_load;
  assign oMemRead   = iReset_n & w_mem_read;
  assign oPcInc     = iReset_n & w_pc_inc;
  assign oIrLoad    = iReset_n & w_ir_load;
  assign oOpLoLoad  = iReset_n & w_op_lo;
  assign oOpHiLoad  = iReset_n & w_op_hi;
  assign oExecStart = iReset_n & w_exec_start;
  assign oHalted    = (r_state == HALT);
  assign oState     = r_state;
  assign oRetired   = r_retired;

endmodule

// File: doc/sap2_control_sequencer.md
Name: sap2_control_sequencer

Overview:
- Sequences the SAP-2 instruction register and fetch path: address phase, memory read, opcode capture, operand-byte fetch, execute handshake, halt.
- Sits between the program counter, MAR, memory and instruction register on one side and the execution datapath on the other.
- Drives the instruction register load enable. Decodes instruction length (1/2/3 bytes) from the latched opcode.

Parameters:
- HLT_OPCODE, 8'h76, opcode that halts the sequencer.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- iClk  input  1  system clock, all state changes on rising edge.
- iReset_n  input  1  asynchronous active-low reset.
- iInstruction  input  8  opcode currently held in the instruction register.
- iMemReady  input  1  memory read data valid this cycle.
- iExecDone  input  1  execution datapath finished current instruction.
- oPcOut  output  1  drive PC onto address bus.
- oMarLoad  output  1  load MAR from address bus.
- oMemRead  output  1  memory read strobe.
- oPcInc  output  1  increment PC.
- oIrLoad  output  1  instruction register load enable.
- oOpLoLoad  output  1  load operand low-byte register.
- oOpHiLoad  output  1  load operand high-byte register.
- oExecStart  output  1  one-cycle execute request.
- oHalted  output  1  sequencer halted.
- oState  output  4  current state encoding (debug).
- oRetired  output  RETIRE_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock iClk. Reset iReset_n is asynchronous and active-low.
- Reset: state=F_ADDR, oRetired=0, byte counter=0, all strobes 0, oHalted=0. Reset mid-operation aborts at once; no strobe survives reset assertion.
- States and encodings: F_ADDR=0, F_MEM=1, DECODE=2, O_ADDR=3, O_MEM=4, EXEC=5, WAIT=6, HALT=7.
- Strobes are Moore-decoded from state, except the iMemReady-qualified strobes listed below (Mealy).
- F_ADDR: oPcOut=1, oMarLoad=1. Next state F_MEM.
- F_MEM: oMemRead=1.
  - iMemReady=0: stay.
  - iMemReady=1: oIrLoad=1 and oPcInc=1 the same cycle, then DECODE.
- DECODE: iInstruction is valid (IR updated on the previous edge).
  - Length 3: 3A,32,C3,CD,FA,C2,CA.
  - Length 2: 3E,06,0E,E6,F6,EE,DB,D3.
  - HLT_OPCODE: go to HALT.
  - All other opcodes: length 1.
  - Length>1: bytes_left=length-1, operand index=0, next O_ADDR. Otherwise next EXEC.
- O_ADDR: oPcOut=1, oMarLoad=1. Next O_MEM.
- O_MEM: oMemRead=1. Wait on iMemReady. When ready:
  - oPcInc=1, plus oOpLoLoad (index 0) or oOpHiLoad (index 1).
  - bytes_left decrements; index increments.
  - Next O_ADDR if bytes_left becomes nonzero, else EXEC.
- EXEC: oExecStart=1 for exactly one cycle. Next WAIT.
- WAIT: hold until iExecDone=1, then oRetired+1 (wraps modulo 2^RETIRE_W) and go to F_ADDR.
- EXEC/iExecDone overlap: iExecDone sampled in EXEC is ignored; only WAIT samples it.
- HALT: oHalted=1, all strobes 0, oRetired increments once on entry (HLT counts as retired). Only reset leaves HALT.
- Mutual exclusion: oIrLoad never overlaps oOpLoLoad/oOpHiLoad. oOpLoLoad and oOpHiLoad are never both 1.
- Latency with iMemReady tied high:
  - 1-byte instruction: F_ADDR→F_MEM→DECODE→EXEC→WAIT, 4 cycles + WAIT.
  - Each operand byte adds 2 cycles.
  - Each iMemReady-low cycle adds 1 cycle.
- iInstruction changing outside DECODE has no effect.

Test Plan:
- Reset: iReset_n low mid-O_MEM (asynchronous) → oState=0, all strobes 0, oRetired=0 immediately.
- NOP: iMemReady=1, opcode 00, iExecDone=1 in WAIT:
  - oIrLoad pulses once (cycle 2).
  - oExecStart at cycle 4.
  - oRetired=1, then back to F_ADDR.
- LDA 3A, iMemReady=1:
  - oOpLoLoad on the first operand read, oOpHiLoad on the second.
  - oPcInc pulses 3 times total.
  - oExecStart 1 cycle after the hi load.
- MVI A 3E with iMemReady low 3 cycles in operand read:
  - O_MEM holds 3 extra cycles with oMemRead=1.
  - oOpLoLoad only when ready.
  - oOpHiLoad never asserted.
- HLT 76: after DECODE, oHalted=1 and oRetired incremented. Stays halted for 50 cycles with strobes 0 regardless of iMemReady/iExecDone. Reset restores fetch.
- iExecDone=1 held in EXEC, then 0 for 5 WAIT cycles, then 1:
  - Retire occurs only on the WAIT-cycle pulse.
  - With RETIRE_W=2, the 4th retire wraps oRetired to 0.
